output_port_serializer: RTL and testbench
=========================================

// Module: output_port_serializer
//
// PURPOSE
// Downstream consumer of the processor's output register. Takes the latched
// 16-bit output word and transmits it on a single UART-style serial pin
// (start bit, LENGTH data bits LSB first, stop bit). A one-entry holding buffer
// lets the core post the next word while the current frame is still shifting.
//
// PARAMETERS
// LENGTH        16  data word width in bits (>=1)
// CLKS_PER_BIT  4   clock cycles each serial bit is held on TxOut (>=1)
//
// PORTS
// clk        in   1       system clock; all logic on rising edge
// Reset      in   1       synchronous, active-high reset
// DataIn     in   LENGTH  word to transmit (output register value)
// DataValid  in   1       DataIn valid this cycle
// Ready      out  1       holding buffer empty; word accepted when DataValid&&Ready
// TxOut      out  1       serial line, idles high
// Busy       out  1       high while a frame is in progress (state != IDLE)
// Done       out  1       one-cycle pulse when a frame's stop bit completes
//
// BEHAVIOUR
// - Reset (sampled at rising clk): TxOut=1, Ready=1, Busy=0, Done=0, buffer
//   empty, bit/cycle counters=0, state=IDLE. Reset mid-frame aborts it: TxOut=1
//   after that edge, pending word discarded, no Done pulse.
// - Accept: at an edge where DataValid&&Ready, DataIn is copied into the buffer;
//   buffer full after the edge; Ready = !buffer_full (registered state only).
//   DataValid while Ready=0 is ignored; the word is not captured.
// - Load: buffer->shift register happens at an edge where the buffer is full and
//   (state==IDLE or the final stop-bit cycle is ending); buffer empties that same
//   edge, so Ready=1 afterwards. Accept and load never coincide (Ready=0 while full).
// - FSM: IDLE -> START -> DATA -> STOP -> IDLE (or -> START if buffer full).
//   START: TxOut=0 for CLKS_PER_BIT cycles.
//   DATA: TxOut=shift[0]; after CLKS_PER_BIT cycles shift right, bit count++;
//         leave after LENGTH bits.
//   STOP: TxOut=1 for CLKS_PER_BIT cycles.
// - Latency: accept at edge k (FSM idle) -> load at edge k+1 -> TxOut=0 from
//   k+1. Frame = (LENGTH+2)*CLKS_PER_BIT cycles; TxOut=1 and state=IDLE (or
//   START of next frame) after edge k+1+(LENGTH+2)*CLKS_PER_BIT.
// - Done: high exactly the one cycle following the edge that ends STOP; pulses
//   even when the next frame starts back-to-back (no idle gap between frames).
// - Busy high from the load edge until the edge ending STOP with no pending word.
// - Counters sized $clog2 of their max+1 (min 1 bit); cycle counter wraps to 0
//   at each bit boundary, bit counter cleared at each load.
// - DataIn is sampled only on accept; later changes do not alter a posted word.
//
// TESTING (LENGTH=16, CLKS_PER_BIT=4)
// 1 Reset held 3 cycles with DataValid=1 -> TxOut=1, Ready=1, Busy=0, Done=0,
//   nothing transmitted after release until a new accept.
// 2 Single word 16'hA5C3 posted when idle -> TxOut: 4 cycles 0, then bits
//   1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (4 cycles each), 4 cycles 1; Done one
//   cycle 73 cycles after accept edge; Busy low afterwards.
// 3 Post 16'h0001 then 16'hFFFF while first frame busy -> Ready=0 until second
//   word loads at first stop end; frames back-to-back, TxOut never idle between;
//   two Done pulses 72 cycles apart.
// 4 Third word 16'h1234 offered while buffer full -> ignored (Ready=0);
//   only the two earlier words appear on TxOut.
// 5 Reset asserted in DATA bit 7 with word pending -> TxOut=1 next cycle, Busy=0,
//   Ready=1, no Done, pending word never transmitted.
// 6 Change DataIn every cycle after accepting 16'h00FF -> transmitted bits match
//   16'h00FF exactly.

Source files
------------

// File: rtl/output_port_serializer.sv
// rtl/output_port_serializer.sv - UART-style serializer for the processor output register
//
// Sends each accepted word as one frame on TxOut: a start bit (0), LENGTH data
// bits LSB first, then a stop bit (1). Every bit is held for CLKS_PER_BIT clocks.
// A one-entry holding buffer lets the next word be posted while a frame is shifting.
//
// Ports:
//   clk        system clock, rising edge
//   Reset      synchronous, active-high reset
//   DataIn     word to transmit, sampled only when DataValid && Ready
//   DataValid  DataIn valid this cycle
//   Ready      holding buffer empty
//   TxOut      serial line, idles high
//   Busy       frame in progress
//   Done       one-cycle pulse after a frame's stop bit completes
module output_port_serializer #(
    parameter int LENGTH       = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [LENGTH-1:0] DataIn,
    input  logic              DataValid,
    output logic              Ready,
    output logic              TxOut,
    output logic              Busy,
    output logic              Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LENGTH-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              done_q, done_d;

    logic accept;
    logic bit_end;
    logic stop_end;
    logic load;

    always_comb begin
        accept   = DataValid && !buf_full_q;
        bit_end  = (cyc_q == CYC_LAST);
        stop_end = (state_q == STOP) && bit_end;
        // A pending word follows the previous frame with no idle gap.
        load     = buf_full_q && ((state_q == IDLE) || stop_end);

        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        done_d     = 1'b0;

        // Accept and load are exclusive: accept needs an empty buffer, load a full one.
        if (accept) begin
            buf_d      = DataIn;
            buf_full_d = 1'b1;
        end else if (load) begin
            buf_full_d = 1'b0;
        end

        if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d = buf_q;
            bit_d   = '0;
            cyc_d   = '0;
            state_d = START;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            cyc_q      <= '0;
            bit_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        TxOut = 1'b1;
        case (state_q)
            IDLE:    TxOut = 1'b1;
            START:   TxOut = 1'b0;
            DATA:    TxOut = shift_q[0];
            STOP:    TxOut = 1'b1;
            default: TxOut = 1'b1;
        endcase
    end

    assign Ready = !buf_full_q;
    assign Busy  = (state_q != IDLE);
    assign Done  = done_q;

endmodule

// File: tb/tb_output_port_serializer.sv
// tb/tb_output_port_serializer.sv - scoreboard bench for output_port_serializer
module tb_output_port_serializer;

    localparam int L   = 16;
    localparam int CPB = 4;
    localparam int FR  = (L + 2) * CPB;

    logic         clk;
    logic         Reset;
    logic [L-1:0] DataIn;
    logic         DataValid;
    logic         Ready;
    logic         TxOut;
    logic         Busy;
    logic         Done;

    output_port_serializer #(.LENGTH(L), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .DataIn   (DataIn),
        .DataValid(DataValid),
        .Ready    (Ready),
        .TxOut    (TxOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [L-1:0] w;
        int           exp_start;
    } item_t;

    item_t q[$];

    int checks = 0;
    int errors = 0;

    bit          mon_active   = 1'b0;
    bit          stray        = 1'b0;
    bit          model_ready  = 1'b1;
    int          mon_cnt      = 0;
    int          prev_start   = 0;
    int          exp_done_cyc = -1;
    logic [FR-1:0] samp;

    task automatic check(input string name, input logic [FR-1:0] act, input logic [FR-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        if (errors <= 40) $display("FAIL %s cycle=%0d actual=event required=none", name, cyc);
    endtask

    // Expected line level for every cycle of one frame.
    function automatic logic [FR-1:0] frame_of(input logic [L-1:0] w);
        logic [FR-1:0] f;
        for (int c = 0; c < FR; c++) begin
            int b;
            b = c / CPB;
            if (b == 0)       f[c] = 1'b0;
            else if (b <= L)  f[c] = w[b-1];
            else              f[c] = 1'b1;
        end
        return f;
    endfunction

    always @(negedge clk) begin
        item_t it;
        int    exp_s;
        if (Reset) begin
            mon_active   = 1'b0;
            mon_cnt      = 0;
            stray        = 1'b0;
            exp_done_cyc = -1;
            model_ready  = 1'b1;
        end else begin
            check("done", FR'(Done), FR'(cyc == exp_done_cyc));
            if (!mon_active && TxOut === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                samp       = '0;
                if (q.size() == 0) begin
                    stray = 1'b1;
                    fail_now("unexpected_frame");
                end else begin
                    stray = 1'b0;
                    exp_s = (q[0].exp_start >= 0) ? q[0].exp_start : prev_start + FR;
                    check("start_cycle", FR'(cyc), FR'(exp_s));
                end
                prev_start = cyc;
            end
            check("busy", FR'(Busy), FR'(mon_active));
            if (mon_active) begin
                samp[mon_cnt] = TxOut;
                mon_cnt++;
                if (mon_cnt == FR) begin
                    mon_active   = 1'b0;
                    exp_done_cyc = cyc + 1;
                    if (!stray) begin
                        it = q.pop_front();
                        check("frame", samp, frame_of(it.w));
                    end
                end
            end else begin
                check("idle_line", FR'(TxOut), FR'(1));
            end
            model_ready = (q.size() - ((mon_active && !stray) ? 1 : 0)) == 0;
            check("ready", FR'(Ready), FR'(model_ready));
        end
    end

    task automatic apply_reset(input int n);
        Reset = 1'b1;
        q.delete();
        repeat (n) @(posedge clk);
        #1;
        check("rst_txout", FR'(TxOut), FR'(1));
        check("rst_ready", FR'(Ready), FR'(1));
        check("rst_busy",  FR'(Busy),  FR'(0));
        check("rst_done",  FR'(Done),  FR'(0));
        Reset     = 1'b0;
        DataValid = 1'b0;
    endtask

    task automatic post(input logic [L-1:0] w);
        int    tries;
        item_t it;
        tries = 0;
        forever begin
            @(negedge clk);
            #1;
            if (model_ready) break;
            tries++;
            if (tries > 2000) begin
                fail_now("post_timeout");
                return;
            end
        end
        DataValid = 1'b1;
        DataIn    = w;
        @(posedge clk);
        #1;
        it.w         = w;
        it.exp_start = (q.size() == 0) ? cyc + 1 : -1;
        q.push_back(it);
        DataValid = 1'b0;
        DataIn    = L'($urandom);
    endtask

    // Offer a word only while the model says the buffer is full.
    task automatic offer_blocked(input logic [L-1:0] w, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            DataValid = !model_ready;
            DataIn    = w;
        end
        @(negedge clk);
        #1;
        DataValid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((q.size() != 0 || mon_active) && n < max) begin
            @(posedge clk);
            n++;
        end
        if (n >= max) fail_now("idle_timeout");
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int waited;
        Reset     = 1'b1;
        DataValid = 1'b1;
        DataIn    = 16'hBEEF;
        apply_reset(3);
        repeat (20) @(posedge clk);

        post(16'hA5C3);
        wait_idle(300);

        post(16'h0001);
        post(16'hFFFF);
        offer_blocked(16'h1234, 10);
        wait_idle(400);

        post(16'h00FF);
        repeat (80) begin
            @(posedge clk);
            #1;
            DataIn = L'($urandom);
        end
        wait_idle(300);

        post(16'h5A5A);
        post(16'hC0DE);
        waited = 0;
        while (!(mon_active && mon_cnt >= 1 + CPB + 7 * CPB) && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 500) fail_now("bit7_timeout");
        @(posedge clk);
        #1;
        apply_reset(1);
        repeat (200) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 90);
            repeat (gap) begin
                @(negedge clk);
                #1;
                DataIn = L'($urandom);
            end
            post(L'($urandom));
        end
        wait_idle(4000);
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
